// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32 subset controller:
// ALU operations, FSM states, opcodes and datapath mux selects.
package cpu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLT = 4'd8
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ    = 3'b000;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;

  localparam logic [1:0] SRC_B_RS2    = 2'd0;
  localparam logic [1:0] SRC_B_IMM    = 2'd1;
  localparam logic [1:0] SRC_B_FOUR   = 2'd2;

  localparam logic [1:0] RES_ALU_OUT    = 2'd0;
  localparam logic [1:0] RES_MEM_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU_RESULT = 2'd2;

  // Instruction retires when its final state hands control back to FETCH.
  function automatic logic retires(state_t s, logic mem_ready);
    return (s == S_MEM_WB) || (s == S_ALU_WB) || (s == S_BRANCH) ||
           ((s == S_MEM_WRITE) && mem_ready);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7_5 of an R- or I-type instruction to an ALU operation.
// SUB only exists for R-type; immediate forms of funct3=000 are always ADD.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_t    alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:         alu_op = ((opcode == OP_R_TYPE) && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:         alu_op = ALU_SLL;
      3'b010, 3'b011: alu_op = ALU_SLT;
      3'b100:         alu_op = ALU_XOR;
      3'b101:         alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110:         alu_op = ALU_OR;
      3'b111:         alu_op = ALU_AND;
      default:        alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM with memory-wait handling and a
// retired-instruction counter.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic [2:0]             funct3,
  input  logic                   funct7_5,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   ir_write,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic                   adr_src,
  output logic                   halted,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             result_src,
  output logic [3:0]             alu_op,
  output logic [3:0]             state_check,
  output logic [COUNT_WIDTH-1:0] retired_check
);

  state_t                 state;
  state_t                 next_state;
  alu_op_t                decoded_op;
  alu_op_t                alu_op_e;
  logic [COUNT_WIDTH-1:0] retired;

  alu_decoder u_alu_decoder (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (decoded_op)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (retires(state, mem_ready)) retired <= retired + COUNT_WIDTH'(1);
    end
  end

  always_comb begin
    next_state = state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    halted     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALU_OUT;
    alu_op_e   = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next_state = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
        if (opcode == OP_R_TYPE)                          next_state = S_EXEC_R;
        else if (opcode == OP_I_TYPE)                     next_state = S_EXEC_I;
        else if (opcode == OP_LOAD || opcode == OP_STORE) next_state = S_MEM_ADR;
        else if (opcode == OP_BRANCH && funct3 == F3_BEQ) next_state = S_BRANCH;
        else                                              next_state = S_HALT;
      end
      S_MEM_ADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEM_DATA;
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op_e   = decoded_op;
        next_state = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op_e   = decoded_op;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op_e   = ALU_SUB;
        pc_write   = zero;
        next_state = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset silences every output immediately, not just after the edge.
    if (!reset) begin
      next_state = S_FETCH;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      halted     = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      result_src = RES_ALU_OUT;
      alu_op_e   = ALU_ADD;
    end
  end

  assign alu_op        = alu_op_e;
  assign state_check   = state;
  assign retired_check = retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; a second instance
// with a 2-bit counter shares all inputs to exercise counter wrap.
module tb_multicycle_controller;
  import cpu_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;

  logic        pc_write, ir_write, mem_read, mem_write, reg_write, adr_src, halted;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [3:0]  alu_op, state_check;
  logic [31:0] retired_check;

  logic        pc_write2, ir_write2, mem_read2, mem_write2, reg_write2, adr_src2, halted2;
  logic [1:0]  alu_src_a2, alu_src_b2, result_src2;
  logic [3:0]  alu_op2, state_check2;
  logic [1:0]  retired_check2;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_retired = 0;

  multicycle_controller #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .adr_src(adr_src),
    .halted(halted), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .alu_op(alu_op), .state_check(state_check), .retired_check(retired_check)
  );

  multicycle_controller #(.COUNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write2), .ir_write(ir_write2),
    .mem_read(mem_read2), .mem_write(mem_write2), .reg_write(reg_write2), .adr_src(adr_src2),
    .halted(halted2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .result_src(result_src2),
    .alu_op(alu_op2), .state_check(state_check2), .retired_check(retired_check2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic mr, input logic z);
    opcode    = op;
    funct3    = f3;
    funct7_5  = f7;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected control word order: pcw irw mr mw rw adr hlt | a b res | op
  task automatic check_ctrl(input string tag, input logic [3:0] st,
                            input logic pcw, input logic irw, input logic mr,
                            input logic mw, input logic rw, input logic adr,
                            input logic hlt, input logic [1:0] a, input logic [1:0] b,
                            input logic [1:0] res, input logic [3:0] op);
    logic [16:0] expected;
    expected = {pcw, irw, mr, mw, rw, adr, hlt, a, b, res, op};
    check_output({tag, " state"}, 32'(state_check), 32'(st));
    check_output({tag, " ctrl"}, 32'({pc_write, ir_write, mem_read, mem_write, reg_write,
                 adr_src, halted, alu_src_a, alu_src_b, result_src, alu_op}), 32'(expected));
    check_output({tag, " ctrl2"}, 32'({pc_write2, ir_write2, mem_read2, mem_write2, reg_write2,
                 adr_src2, halted2, alu_src_a2, alu_src_b2, result_src2, alu_op2}), 32'(expected));
    check_output({tag, " state2"}, 32'(state_check2), 32'(st));
  endtask

  task automatic check_retired(input string tag);
    check_output({tag, " retired"}, retired_check, exp_retired);
    check_output({tag, " retired2"}, 32'(retired_check2), 32'(exp_retired[1:0]));
  endtask

  task automatic check_fetch(input string tag);
    check_ctrl({tag, " fetch"}, S_FETCH, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 4'd0);
  endtask

  task automatic check_decode(input string tag);
    check_ctrl({tag, " decode"}, S_DECODE, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 4'd0);
  endtask

  // One R/I instruction end to end with mem_ready held high: 4 cycles.
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f7, input logic [3:0] exp_op);
    apply_stimulus(op, f3, f7, 1'b1, 1'b0);
    check_fetch(tag);
    tick();
    check_decode(tag);
    tick();
    if (op == OP_R_TYPE)
      check_ctrl({tag, " exec_r"}, S_EXEC_R, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, exp_op);
    else
      check_ctrl({tag, " exec_i"}, S_EXEC_I, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, exp_op);
    tick();
    check_ctrl({tag, " alu_wb"}, S_ALU_WB, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    check_retired({tag, " pre"});
    tick();
    exp_retired = exp_retired + 1;
    check_retired({tag, " post"});
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(OP_R_TYPE, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check_ctrl("in_reset", S_FETCH, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    check_retired("in_reset");

    reset = 1'b1;
    #1;

    // Five immediates: second instance counter walks 0,1,2,3,0,1.
    run_alu("addi_f7", OP_I_TYPE, 3'b000, 1'b1, 4'd0);
    run_alu("ori",     OP_I_TYPE, 3'b110, 1'b0, 4'd3);
    run_alu("srai",    OP_I_TYPE, 3'b101, 1'b1, 4'd7);
    run_alu("slti",    OP_I_TYPE, 3'b010, 1'b0, 4'd8);
    run_alu("andi",    OP_I_TYPE, 3'b111, 1'b0, 4'd2);

    run_alu("add",  OP_R_TYPE, 3'b000, 1'b0, 4'd0);
    run_alu("sub",  OP_R_TYPE, 3'b000, 1'b1, 4'd1);
    run_alu("srl",  OP_R_TYPE, 3'b101, 1'b0, 4'd6);
    run_alu("sltu", OP_R_TYPE, 3'b011, 1'b0, 4'd8);
    run_alu("sll",  OP_R_TYPE, 3'b001, 1'b0, 4'd5);
    run_alu("xor",  OP_R_TYPE, 3'b100, 1'b0, 4'd4);

    // Load with a fetch stall and a three-cycle memory wait.
    apply_stimulus(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    check_ctrl("lw fetch_wait", S_FETCH, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 4'd0);
    tick();
    check_ctrl("lw fetch_held", S_FETCH, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 4'd0);
    apply_stimulus(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0);
    check_fetch("lw");
    tick();
    check_decode("lw");
    tick();
    check_ctrl("lw mem_adr", S_MEM_ADR, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0);
    apply_stimulus(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_ctrl("lw mem_read_wait", S_MEM_READ, 0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0);
      tick();
    end
    apply_stimulus(OP_LOAD, 3'b010, 1'b0, 1'b1, 1'b0);
    check_ctrl("lw mem_read_done", S_MEM_READ, 0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    tick();
    check_ctrl("lw mem_wb", S_MEM_WB, 0, 0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd1, 4'd0);
    check_retired("lw pre");
    tick();
    exp_retired = exp_retired + 1;
    check_retired("lw post");

    // Store, no wait.
    apply_stimulus(OP_STORE, 3'b010, 1'b0, 1'b1, 1'b0);
    check_fetch("sw");
    tick();
    check_decode("sw");
    tick();
    check_ctrl("sw mem_adr", S_MEM_ADR, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 4'd0);
    tick();
    check_ctrl("sw mem_write", S_MEM_WRITE, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    tick();
    exp_retired = exp_retired + 1;
    check_retired("sw post");
    check_fetch("after_sw");

    // Branch taken then not taken; both retire.
    apply_stimulus(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b1);
    tick();
    check_decode("beq_t");
    tick();
    check_ctrl("beq_t branch", S_BRANCH, 1, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd1);
    tick();
    exp_retired = exp_retired + 1;
    check_retired("beq_t post");
    apply_stimulus(OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check_ctrl("beq_nt branch", S_BRANCH, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 4'd1);
    tick();
    exp_retired = exp_retired + 1;
    check_retired("beq_nt post");

    // Reset asserted while a store waits on memory.
    apply_stimulus(OP_STORE, 3'b010, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    apply_stimulus(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    check_ctrl("sw_wait mem_write", S_MEM_WRITE, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    tick();
    check_ctrl("sw_wait held", S_MEM_WRITE, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    check_retired("sw_wait held");
    reset = 1'b0;
    #1;
    check_ctrl("sw_wait reset_low", S_MEM_WRITE, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    tick();
    exp_retired = 0;
    check_ctrl("sw_wait after_reset", S_FETCH, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    check_retired("sw_wait after_reset");
    reset = 1'b1;
    #1;

    run_alu("add2", OP_R_TYPE, 3'b000, 1'b0, 4'd0);

    // Illegal opcode halts with the counter frozen.
    apply_stimulus(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b0);
    check_fetch("illegal");
    tick();
    check_decode("illegal");
    tick();
    for (int i = 0; i < 3; i++) begin
      check_ctrl("halt", S_HALT, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'd0);
      check_retired("halt");
      tick();
    end
    reset = 1'b0;
    #1;
    check_ctrl("halt reset_low", S_HALT, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'd0);
    tick();
    exp_retired = 0;
    check_retired("halt after_reset");
    reset = 1'b1;
    #1;
    check_fetch("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter COUNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 opcode  input  7  instruction register bits [6:0].
REQ-005 funct3  input  3  instruction register bits [14:12].
REQ-006 funct7_5  input  1  instruction register bit 30.
REQ-007 zero  input  1  ALU result == 0 flag.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 Outputs, all 1 bit: pc_write, ir_write, mem_read, mem_write, reg_write, adr_src (0=PC, 1=ALU-out register), halted.
REQ-010 alu_src_a  output  2  0=PC, 1=old PC, 2=rs1 data.
REQ-011 alu_src_b  output  2  0=rs2 data, 1=imm_ext, 2=constant 4.
REQ-012 result_src  output  2  0=ALU-out register, 1=memory data, 2=ALU result.
REQ-013 alu_op  output  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8.
REQ-014 state_check  output  4  current state encoding; retired_check  output  COUNT_WIDTH  retired instructions.

Function
REQ-015 States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, HALT; all outputs are Moore except pc_write, ir_write and the wait transitions, which are qualified by mem_ready or zero.
REQ-016 Unlisted outputs are 0 in every state; alu_op defaults to ADD.
REQ-017 FETCH: mem_read=1, adr_src=0, alu_src_a=0, alu_src_b=2, ADD, result_src=2; ir_write=pc_write=mem_ready; to DECODE when mem_ready, else remain.
REQ-018 DECODE: alu_src_a=1, alu_src_b=1, ADD; next on opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011 or 0100011->MEM_ADR, 1100011 with funct3=000->BRANCH, anything else->HALT.
REQ-019 MEM_ADR: alu_src_a=2, alu_src_b=1, ADD; to MEM_READ if opcode=0000011, else MEM_WRITE.
REQ-020 MEM_READ: mem_read=1, adr_src=1; to MEM_WB when mem_ready, else remain.
REQ-021 MEM_WB: result_src=1, reg_write=1; to FETCH.
REQ-022 MEM_WRITE: mem_write=1, adr_src=1; to FETCH when mem_ready, else remain.
REQ-023 EXEC_R: alu_src_a=2, alu_src_b=0; funct3 000->ADD (SUB if funct7_5), 001->SLL, 010/011->SLT, 100->XOR, 101->SRL (SRA if funct7_5), 110->OR, 111->AND; to ALU_WB.
REQ-024 EXEC_I: alu_src_a=2, alu_src_b=1; same map as REQ-023 except funct3=000 is always ADD; to ALU_WB.
REQ-025 ALU_WB: result_src=0, reg_write=1; to FETCH.
REQ-026 BRANCH: alu_src_a=2, alu_src_b=0, SUB, result_src=0, pc_write=zero; to FETCH.
REQ-027 HALT: halted=1, all strobes 0; remains until reset.
REQ-028 Counter increments by 1 in the cycle that leaves MEM_WB, ALU_WB, BRANCH, or MEM_WRITE with mem_ready=1; wraps modulo 2^COUNT_WIDTH.
REQ-029 mem_read and mem_write are never both 1; at most one of pc_write, reg_write, mem_write, ir_write is 1, except FETCH (pc_write with ir_write).
REQ-030 Minimum latency with mem_ready tied high: R/I 4 cycles, lw 5, sw 4, beq 3.

Reset
REQ-031 reset=0 at a rising edge: next state FETCH, counter 0, halted 0, regardless of current state or pending memory wait.
REQ-032 While reset=0, all strobes are 0; on the first edge with reset=1 the controller is in FETCH and issues mem_read.

Structure
REQ-033 Package cpu_pkg holds alu_op_t, the state enum, opcode constants and the mux-select encodings.
REQ-034 One sub-module, alu_decoder, maps opcode/funct3/funct7_5 to alu_op for EXEC_R/EXEC_I.

Verification
REQ-035 add (opcode 0110011, funct3 000, funct7_5 0), mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_op 0),ALU_WB(reg_write 1), retired 0->1.
REQ-036 lw with mem_ready low 3 cycles in MEM_READ -> stays MEM_READ 3 cycles, mem_read=1, adr_src=1, then MEM_WB with result_src=1.
REQ-037 beq with zero=1 in BRANCH -> pc_write=1, alu_op=1; repeated with zero=0 -> pc_write=0; both retire.
REQ-038 opcode 1111111 -> HALT after DECODE, halted=1, counter frozen, until reset=0.
REQ-039 reset=0 during MEM_WRITE wait -> next cycle FETCH, counter 0, mem_write 0.
REQ-040 COUNT_WIDTH=2, five retired addi -> retired_check 0,1,2,3,0,1.
